// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: MSB-first serial pattern transmitter (start/pattern/len/reps/gap/abort in; out/out_valid/busy/done/err/state out)
module seq_pattern_gen #(
  parameter int PAT_W = 16,
  parameter int LEN_W = 5,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [CNT_W-1:0] reps,
  input  logic [GAP_W-1:0] gap,
  input  logic             abort,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       state
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  logic [PAT_W-1:0] pat_q, in_sh, first_sh, next_sh;
  logic [LEN_W-1:0] len_q, idx;
  logic [CNT_W-1:0] reps_q, rep_cnt;
  logic [GAP_W-1:0] gap_q, gap_cnt;
  logic             legal, last_rep;
  assign legal    = len != '0 && len <= LEN_W'(PAT_W);
  assign in_sh    = pattern >> (len - 1'b1);
  assign first_sh = pat_q >> (len_q - 1'b1);
  assign next_sh  = pat_q >> (idx - 1'b1);
  assign last_rep = reps_q != '0 && rep_cnt + 1'b1 == reps_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      out       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      pat_q     <= '0;
      len_q     <= '0;
      reps_q    <= '0;
      gap_q     <= '0;
      idx       <= '0;
      rep_cnt   <= '0;
      gap_cnt   <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!abort && start && legal) begin
            pat_q     <= pattern;
            len_q     <= len;
            reps_q    <= reps;
            gap_q     <= gap;
            idx       <= len - 1'b1;
            rep_cnt   <= '0;
            out       <= in_sh[0];
            out_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= S_SEND;
          end else if (!abort && start) begin
            err <= 1'b1;
          end
        end
        S_SEND: begin
          if (abort) begin
            state     <= S_IDLE;
            out       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end else if (idx != '0) begin
            idx <= idx - 1'b1;
            out <= next_sh[0];
          end else if (last_rep) begin
            state     <= S_DONE;
            out       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            if (reps_q != '0) rep_cnt <= rep_cnt + 1'b1;
            if (gap_q != '0) begin
              state     <= S_GAP;
              gap_cnt   <= gap_q - 1'b1;
              out       <= 1'b0;
              out_valid <= 1'b0;
            end else begin
              idx <= len_q - 1'b1;
              out <= first_sh[0];
            end
          end
        end
        S_GAP: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (gap_cnt == '0) begin
            state     <= S_SEND;
            idx       <= len_q - 1'b1;
            out       <= first_sh[0];
            out_valid <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/seq_pattern_gen.md
Name: seq_pattern_gen

Overview:
- Serial bit-pattern transmitter, the generating end of the team's serial sequence-detector path.
- Takes a programmable pattern of 1..PAT_W bits and emits it MSB-first, one bit per clock, on `out`.
- Supports a programmable repeat count and inserted idle gap bits.
- Used as the stimulus source for our serial detector FSMs and as a standalone serial framer.

Parameters:
- PAT_W, 16, max pattern length in bits
- LEN_W, 5, width of `len`; must satisfy 2^LEN_W > PAT_W
- CNT_W, 8, width of the repeat counter
- GAP_W, 4, width of the gap length

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request transmission; sampled only in IDLE
- pattern  input  PAT_W  bits to send; bit len-1 is sent first, bit 0 last
- len  input  LEN_W  pattern length; legal range 1..PAT_W
- reps  input  CNT_W  number of pattern transmissions; 0 = continuous until abort
- gap  input  GAP_W  idle cycles inserted between repetitions
- abort  input  1  terminate any transmission
- out  output  1  serial data bit
- out_valid  output  1  high when `out` carries a pattern bit
- busy  output  1  high in SEND and GAP
- done  output  1  one-cycle pulse at normal completion
- err  output  1  one-cycle pulse when start is rejected
- state  output  2  current FSM state: 0 IDLE, 1 SEND, 2 GAP, 3 DONE

Behaviour:
- Clock and reset: one clock (`clk`). Reset is asynchronous and active-low (`rst_n`).
- Reset state: state=IDLE. out, out_valid, busy, done and err are all 0. All internal counters are 0.
- All outputs are registered. There is no combinational path from any input to any output.

IDLE
- start=1 with 1<=len<=PAT_W: latch pattern, len, reps and gap. Next cycle: state=SEND, out=pattern[len-1], out_valid=1, busy=1. First-bit latency is 1 cycle after the start edge.
- start=1 with len=0 or len>PAT_W: err=1 for one cycle, state stays IDLE, out_valid=0.
- abort=1 in IDLE has no effect. If start and abort are both high in IDLE, abort wins: start is ignored and err is not asserted.

SEND
- Emits one bit per cycle, in order: bit len-1, bit len-2, ..., bit 0. out_valid=1 for exactly len consecutive cycles per repetition.
- After bit 0, if repetitions remain (or reps=0):
  - gap>0: go to GAP.
  - gap=0: go directly to bit len-1 of the next repetition, with no bubble.
- After bit 0 of the last repetition: go to DONE.

GAP
- Lasts exactly `gap` cycles, with out=0, out_valid=0, busy=1. Then go to SEND at bit len-1.

DONE
- Lasts exactly 1 cycle, with done=1, busy=0, out=0, out_valid=0. Then go to IDLE.
- start is ignored in DONE and is accepted starting from the following IDLE cycle.

Abort and restart
- abort=1 in SEND or GAP: next cycle state=IDLE with out=0, out_valid=0, busy=0. done is not pulsed.
- start while busy is ignored silently: no err pulse, and the latched values are unchanged.

Repeat counter
- Counts completed repetitions. Comparison is against the latched `reps`.
- reps=0 never terminates; the counter is not incremented and does not wrap.
- reps=2^CNT_W-1 must complete all repetitions exactly.

Input changes
- Changes to pattern, len, reps or gap during a transmission do not affect the transmission in progress.

Asynchronous reset mid-transmission
- Immediately forces the reset values; no partial bit is output.

Test Plan:
- T1, single pattern: pattern=7'b1110010, len=7, reps=1, gap=0; start at edge T → out over T+1..T+7 = 1,1,1,0,0,1,0 with out_valid=1; done=1 at T+8; state=IDLE at T+9.
- T2, repeat with gap: same pattern, reps=2, gap=3 → bits at T+1..T+7; out_valid=0 at T+8..T+10 with state=GAP; bits again at T+11..T+17; done at T+18.
- T3, illegal length: start with len=0, then with len=17 → err pulses once for each, state stays 0, out_valid never asserts.
- T4, abort: abort after the 3rd bit of T1 → next cycle state=IDLE, out_valid=0, done never pulses; a new start on the following cycle is accepted normally.
- T5, boundaries: len=1, pattern bit0=1, reps=0, gap=0 → out=1 and out_valid=1 continuously for 40 cycles; abort stops it. Then len=16, pattern=16'hA5C3 → 16 bits emitted in the order 1010_0101_1100_0011.
- T6, reset mid-GAP: drop rst_n between clock edges while in GAP → all outputs 0 immediately; state=IDLE; after release, start is accepted normally.
